// File: rtl/fdiv_sched_if.sv
// fdiv_sched_if: request, fdiv operand/result and tagged response signals of the fdiv sequencer
interface fdiv_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic [31:0]        fdiv_x1;
    logic [31:0]        fdiv_x2;
    logic [31:0]        fdiv_y;
    logic               fdiv_ovf;
    logic               fdiv_udf;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_y;
    logic               resp_ovf;
    logic               resp_udf;
    logic               busy;
    modport slave (
        input  req_valid, req_x1, req_x2, fdiv_y, fdiv_ovf, fdiv_udf, resp_ready,
        output req_ready, fdiv_x1, fdiv_x2, resp_valid, resp_id, resp_y, resp_ovf, resp_udf, busy
    );
    modport master (
        output req_valid, req_x1, req_x2, fdiv_y, fdiv_ovf, fdiv_udf, resp_ready,
        input  req_ready, fdiv_x1, fdiv_x2, resp_valid, resp_id, resp_y, resp_ovf, resp_udf, busy
    );
endinterface

// File: rtl/fdiv_sched.sv
// fdiv_sched: round-robin sequencer sharing one combinational fdiv between NREQ requesters,
// holding captured operands for LAT cycles before sampling the result into a tagged response
module fdiv_sched #(
    parameter int NREQ = 2,
    parameter int LAT  = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic         clk,
    input logic         rst,
    fdiv_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] ix;
    logic [3:0]     cnt;
    logic           any;
    logic [31:0]    sel_x1;
    logic [31:0]    sel_x2;
    // descending scan so the valid index closest to rr_ptr wins
    always_comb begin
        grant = '0;
        any = 1'b0;
        ix = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            ix = IDW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[ix]) begin
                grant = ix;
                any = 1'b1;
            end
        end
    end
    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_x1 = bus.req_x1[32*i +: 32];
                sel_x2 = bus.req_x2[32*i +: 32];
            end
        end
    end
    assign bus.req_ready = (state == IDLE && any && !rst) ? NREQ'(1) << grant : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            bus.fdiv_x1 <= '0;
            bus.fdiv_x2 <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id <= '0;
            bus.resp_y <= '0;
            bus.resp_ovf <= 1'b0;
            bus.resp_udf <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        bus.fdiv_x1 <= sel_x1;
                        bus.fdiv_x2 <= sel_x2;
                        bus.resp_id <= grant;
                        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        cnt <= 4'(LAT - 1);
                        bus.busy <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        bus.resp_y <= bus.fdiv_y;
                        bus.resp_ovf <= bus.fdiv_ovf;
                        bus.resp_udf <= bus.fdiv_udf;
                        bus.resp_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
